// File: rtl/spi_pkg.sv
// spi_pkg: mode decode, byte width and FSM state shared by the SPI responder
package spi_pkg;
  localparam int BITS_PER_BYTE = 8;
  typedef enum logic {IDLE, ACTIVE} state_t;
  function automatic logic cpol_of(input int mode);
    return mode == 2 || mode == 3;
  endfunction
  function automatic logic cpha_of(input int mode);
    return mode == 1 || mode == 3;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: two-flop synchroniser plus history flop with rise/fall flags
module spi_sync_edge #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic meta, hist;
  always_ff @(posedge clk or posedge rst)
    if (rst) {meta, sync, hist} <= {3{INIT}};
    else {meta, sync, hist} <= {d, meta, sync};
  assign rise = sync & ~hist;
  assign fall = ~sync & hist;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI responder sampling SCK/CS_n/MOSI in i_Clk, MSb-first RX deserialiser
// and one-deep buffered TX serialiser for all four SPI modes
module spi_slave
  import spi_pkg::*;
#(
  parameter int         SPI_MODE  = 0,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_Busy,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En
);
  localparam logic CPOL = cpol_of(SPI_MODE);
  localparam logic CPHA = cpha_of(SPI_MODE);
  state_t state, state_d;
  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi;
  logic [1:0] unused_sync, unused_mosi_edges;
  logic [2:0] cnt;
  logic [BITS_PER_BYTE-2:0] rx_sh;
  logic [7:0] tx_sh, pend, next_tx;
  logic pend_v, active, lead, trail, sample, shift, wrap, start, load;
  spi_sync_edge #(.INIT(CPOL)) u_sck (
    .clk(i_Clk), .rst(i_Rst), .d(i_SPI_Clk),
    .sync(unused_sync[0]), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync_edge #(.INIT(1'b1)) u_cs (
    .clk(i_Clk), .rst(i_Rst), .d(i_SPI_CS_n),
    .sync(unused_sync[1]), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.INIT(1'b0)) u_mosi (
    .clk(i_Clk), .rst(i_Rst), .d(i_SPI_MOSI),
    .sync(mosi), .rise(unused_mosi_edges[0]), .fall(unused_mosi_edges[1])
  );
  // CS deassertion masks any coincident SCK edge so the counter clear wins
  always_comb begin
    active  = state == ACTIVE;
    lead    = CPOL ? sck_fall : sck_rise;
    trail   = CPOL ? sck_rise : sck_fall;
    sample  = active && !cs_rise && (CPHA ? trail : lead);
    shift   = active && !cs_rise && (CPHA ? lead : trail);
    wrap    = sample && cnt == 3'(BITS_PER_BYTE - 1);
    start   = !active && cs_fall;
    load    = start || wrap;
    next_tx = pend_v ? pend : IDLE_BYTE;
    state_d = start ? ACTIVE : (active && cs_rise) ? IDLE : state;
  end
  always_ff @(posedge i_Clk or posedge i_Rst)
    if (i_Rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge i_Clk or posedge i_Rst)
    if (i_Rst) begin
      cnt        <= '0;
      rx_sh      <= '0;
      o_RX_Byte  <= 8'h00;
      o_RX_DV    <= 1'b0;
      tx_sh      <= IDLE_BYTE;
      pend       <= 8'h00;
      pend_v     <= 1'b0;
      o_SPI_MISO <= IDLE_BYTE[7];
    end else begin
      o_RX_DV <= wrap;
      if (sample) begin
        rx_sh <= {rx_sh[BITS_PER_BYTE-3:0], mosi};
        cnt   <= cnt + 3'd1;
      end
      if (wrap) o_RX_Byte <= {rx_sh, mosi};
      if (start || (active && cs_rise)) cnt <= '0;
      if (load) pend_v <= 1'b0;
      // a strobe landing on a load refills the buffer for the following slot
      if (i_TX_DV && !pend_v) begin
        pend   <= i_TX_Byte;
        pend_v <= 1'b1;
      end
      if (start && !CPHA) begin
        o_SPI_MISO <= next_tx[7];
        tx_sh      <= {next_tx[6:0], 1'b0};
      end else if (load) tx_sh <= next_tx;
      else if (shift) begin
        o_SPI_MISO <= tx_sh[7];
        tx_sh      <= {tx_sh[6:0], 1'b0};
      end
    end
  assign o_TX_Ready    = !pend_v;
  assign o_Busy        = active;
  assign o_SPI_MISO_En = active;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench driving one responder per SPI mode from a bit-banged master
module tb_spi_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] sck = 4'b1100;
  logic [3:0] cs_n = 4'hF;
  logic [3:0] mosi = 4'h0;
  logic [3:0] tx_dv = 4'h0;
  logic [3:0] tx_ready, rx_dv, busy, miso, miso_en;
  logic [7:0] tx_byte [4];
  logic [7:0] rx_byte [4];
  int dv_cnt [4] = '{0, 0, 0, 0};
  logic [7:0] dv_byte [4];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.SPI_MODE(g), .IDLE_BYTE(8'hFF)) u_dut (
      .i_Clk(clk), .i_Rst(rst),
      .i_TX_Byte(tx_byte[g]), .i_TX_DV(tx_dv[g]), .o_TX_Ready(tx_ready[g]),
      .o_RX_DV(rx_dv[g]), .o_RX_Byte(rx_byte[g]), .o_Busy(busy[g]),
      .i_SPI_Clk(sck[g]), .i_SPI_CS_n(cs_n[g]), .i_SPI_MOSI(mosi[g]),
      .o_SPI_MISO(miso[g]), .o_SPI_MISO_En(miso_en[g])
    );
  end

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (rx_dv[i]) begin
        dv_cnt[i]  <= dv_cnt[i] + 1;
        dv_byte[i] <= rx_byte[i];
      end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic queue(input int m, input logic [7:0] b);
    tx_byte[m] = b;
    tx_dv[m] = 1'b1;
    tick(1);
    tx_dv[m] = 1'b0;
  endtask

  task automatic cs_low(input int m);
    cs_n[m] = 1'b0;
    tick(4);
  endtask

  task automatic cs_high(input int m);
    tick(4);
    cs_n[m] = 1'b1;
    tick(6);
  endtask

  // half SCK period = 4 i_Clk cycles
  task automatic xfer(input int m, input logic [7:0] tx, output logic [7:0] rx);
    logic pol, pha;
    pol = m >= 2;
    pha = (m % 2) == 1;
    for (int i = 7; i >= 0; i--) begin
      if (!pha) mosi[m] = tx[i];
      tick(4);
      sck[m] = ~pol;
      if (pha) mosi[m] = tx[i];
      else rx[i] = miso[m];
      tick(4);
      sck[m] = pol;
      if (pha) rx[i] = miso[m];
    end
    tick(6);
  endtask

  task automatic test_reset();
    tick(3);
    for (int m = 0; m < 4; m++) begin
      n_cmp++;
      if ({tx_ready[m], rx_dv[m], busy[m], miso[m], miso_en[m], rx_byte[m]} !== {5'b10010, 8'h00}) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: got %b/%h want 10010/00", m,
                 {tx_ready[m], rx_dv[m], busy[m], miso[m], miso_en[m]}, rx_byte[m]);
      end
    end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_mode0_loopback();
    logic [7:0] rx;
    int d;
    d = dv_cnt[0];
    queue(0, 8'h3C);
    n_cmp++;
    if (tx_ready[0] !== 1'b0) begin n_bad++; $display("FAIL m0_ready_full: got %b want 0", tx_ready[0]); end
    cs_low(0);
    n_cmp++;
    if ({tx_ready[0], busy[0], miso_en[0]} !== 3'b111) begin
      n_bad++; $display("FAIL m0_after_cs: got %b want 111", {tx_ready[0], busy[0], miso_en[0]});
    end
    xfer(0, 8'hA5, rx);
    n_cmp++;
    if (rx !== 8'h3C) begin n_bad++; $display("FAIL m0_miso: got %h want 3c", rx); end
    n_cmp++;
    if (dv_cnt[0] - d !== 1) begin n_bad++; $display("FAIL m0_dv_count: got %0d want 1", dv_cnt[0] - d); end
    n_cmp++;
    if (dv_byte[0] !== 8'hA5) begin n_bad++; $display("FAIL m0_rx_byte: got %h want a5", dv_byte[0]); end
    cs_high(0);
    n_cmp++;
    if ({busy[0], miso_en[0]} !== 2'b00) begin
      n_bad++; $display("FAIL m0_release: got %b want 00", {busy[0], miso_en[0]});
    end
  endtask

  task automatic test_modes_burst();
    logic [7:0] rx1, rx2;
    int d;
    for (int m = 1; m < 4; m++) begin
      d = dv_cnt[m];
      cs_low(m);
      queue(m, 8'h55);
      xfer(m, 8'h81, rx1);
      n_cmp++;
      if (rx1 !== 8'hFF) begin n_bad++; $display("FAIL burst_miso1[%0d]: got %h want ff", m, rx1); end
      n_cmp++;
      if (dv_byte[m] !== 8'h81) begin n_bad++; $display("FAIL burst_rx1[%0d]: got %h want 81", m, dv_byte[m]); end
      xfer(m, 8'h7E, rx2);
      n_cmp++;
      if (rx2 !== 8'h55) begin n_bad++; $display("FAIL burst_miso2[%0d]: got %h want 55", m, rx2); end
      n_cmp++;
      if (dv_byte[m] !== 8'h7E) begin n_bad++; $display("FAIL burst_rx2[%0d]: got %h want 7e", m, dv_byte[m]); end
      n_cmp++;
      if (dv_cnt[m] - d !== 2) begin n_bad++; $display("FAIL burst_dv_count[%0d]: got %0d want 2", m, dv_cnt[m] - d); end
      cs_high(m);
    end
  endtask

  task automatic test_empty_buffer();
    logic [7:0] rx;
    cs_low(0);
    xfer(0, 8'h00, rx);
    n_cmp++;
    if (rx !== 8'hFF) begin n_bad++; $display("FAIL empty_idle_byte: got %h want ff", rx); end
    cs_high(0);
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int d;
    d = dv_cnt[0];
    cs_low(0);
    for (int i = 0; i < 5; i++) begin
      mosi[0] = i[0];
      tick(4);
      sck[0] = 1'b1;
      tick(4);
      sck[0] = 1'b0;
    end
    cs_n[0] = 1'b1;
    tick(3);
    n_cmp++;
    if (miso_en[0] !== 1'b0) begin n_bad++; $display("FAIL abort_miso_en: got %b want 0", miso_en[0]); end
    tick(4);
    n_cmp++;
    if (dv_cnt[0] !== d) begin n_bad++; $display("FAIL abort_no_dv: got %0d want 0", dv_cnt[0] - d); end
    cs_low(0);
    xfer(0, 8'h12, rx);
    n_cmp++;
    if (dv_byte[0] !== 8'h12) begin n_bad++; $display("FAIL abort_next_rx: got %h want 12", dv_byte[0]); end
    n_cmp++;
    if (dv_cnt[0] - d !== 1) begin n_bad++; $display("FAIL abort_next_dv: got %0d want 1", dv_cnt[0] - d); end
    cs_high(0);
  endtask

  task automatic test_tx_buffer();
    logic [7:0] rx1, rx2;
    queue(0, 8'h11);
    queue(0, 8'h99);
    n_cmp++;
    if (tx_ready[0] !== 1'b0) begin n_bad++; $display("FAIL txbuf_ready: got %b want 0", tx_ready[0]); end
    cs_low(0);
    xfer(0, 8'h00, rx1);
    n_cmp++;
    if (rx1 !== 8'h11) begin n_bad++; $display("FAIL txbuf_keep_first: got %h want 11", rx1); end
    cs_high(0);
    // CS pin falls here; the load fires on the third rising clock edge after
    cs_n[0] = 1'b0;
    tick(2);
    tx_byte[0] = 8'h5A;
    tx_dv[0] = 1'b1;
    tick(1);
    tx_dv[0] = 1'b0;
    n_cmp++;
    if ({busy[0], tx_ready[0]} !== 2'b10) begin
      n_bad++; $display("FAIL coincide_state: got %b want 10", {busy[0], tx_ready[0]});
    end
    tick(3);
    xfer(0, 8'h00, rx1);
    xfer(0, 8'h00, rx2);
    n_cmp++;
    if ({rx1, rx2} !== 16'hFF5A) begin n_bad++; $display("FAIL coincide_slots: got %h want ff5a", {rx1, rx2}); end
    cs_high(0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    cs_low(0);
    queue(0, 8'h77);
    for (int i = 0; i < 3; i++) begin
      tick(4);
      sck[0] = 1'b1;
      tick(4);
      sck[0] = 1'b0;
    end
    n_cmp++;
    if ({busy[0], tx_ready[0]} !== 2'b10) begin
      n_bad++; $display("FAIL rst_pre: got %b want 10", {busy[0], tx_ready[0]});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({tx_ready[0], rx_dv[0], busy[0], miso[0], miso_en[0], rx_byte[0]} !== {5'b10010, 8'h00}) begin
      n_bad++;
      $display("FAIL rst_mid: got %b/%h want 10010/00",
               {tx_ready[0], rx_dv[0], busy[0], miso[0], miso_en[0]}, rx_byte[0]);
    end
    cs_n[0] = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    cs_low(0);
    xfer(0, 8'hC3, rx);
    n_cmp++;
    if (dv_byte[0] !== 8'hC3) begin n_bad++; $display("FAIL rst_next_rx: got %h want c3", dv_byte[0]); end
    n_cmp++;
    if (rx !== 8'hFF) begin n_bad++; $display("FAIL rst_pend_cleared: got %h want ff", rx); end
    cs_high(0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) tx_byte[i] = 8'h00;
    test_reset();
    test_mode0_loopback();
    test_modes_burst();
    test_empty_buffer();
    test_abort();
    test_tx_buffer();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
